// File: rtl/spi_master_apb_fifo_if.sv
`timescale 1ns/1ps
// APB register front end for the SPI master core: config registers, TX/RX FWFT FIFOs,
// wait states with timeout, PSLVERR decoding and a maskable registered interrupt.
module spi_master_apb_fifo_if #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned NUM_CS         = 4,
  parameter int unsigned LEN_WIDTH      = 16,
  parameter int unsigned WAIT_MAX       = 15
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  input  logic                      PWRITE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic                      spi_rd,
  output logic                      spi_wr,
  output logic                      spi_qrd,
  output logic                      spi_qwr,
  output logic                      spi_swrst,
  output logic [NUM_CS-1:0]         spi_csreg,
  output logic [7:0]                spi_clk_div,
  output logic                      spi_clk_div_valid,
  output logic [31:0]               spi_cmd,
  output logic [31:0]               spi_addr,
  output logic [5:0]                spi_cmd_len,
  output logic [5:0]                spi_addr_len,
  output logic [LEN_WIDTH-1:0]      spi_data_len,
  output logic [15:0]               spi_dummy_rd,
  output logic [15:0]               spi_dummy_wr,
  output logic [31:0]               tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  input  logic [31:0]               rx_data,
  input  logic                      rx_valid,
  output logic                      rx_ready,
  input  logic                      core_busy,
  input  logic                      core_done,
  output logic                      irq
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned AW = LW - 1;
  localparam int unsigned WW = $clog2(WAIT_MAX + 1);
  localparam logic [WW-1:0] WaitMax = WW'(WAIT_MAX);
  localparam logic [LW-1:0] Depth   = LW'(FIFO_DEPTH);

  localparam logic [3:0] IdxStatus = 4'h0;
  localparam logic [3:0] IdxClkDiv = 4'h1;
  localparam logic [3:0] IdxCmd    = 4'h2;
  localparam logic [3:0] IdxAddr   = 4'h3;
  localparam logic [3:0] IdxLen    = 4'h4;
  localparam logic [3:0] IdxDummy  = 4'h5;
  localparam logic [3:0] IdxTxFifo = 4'h6;
  localparam logic [3:0] IdxRxFifo = 4'h8;
  localparam logic [3:0] IdxIntCfg = 4'h9;
  localparam logic [3:0] IdxIntSta = 4'hA;

  logic [3:0]           idx;
  logic                 idx_known, map_err, access, stall, timeout, done_acc, wr_ok, rd_ok;
  logic                 tx_full, tx_empty, rx_full, rx_empty;
  logic                 tx_push, tx_pop, rx_push, rx_pop;
  logic [2:0]           intsta;
  logic                 unused_bits;

  logic [31:0]          tx_mem_q [FIFO_DEPTH];
  logic [31:0]          rx_mem_q [FIFO_DEPTH];
  logic [AW-1:0]        tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [AW-1:0]        rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [LW-1:0]        tx_level_q, tx_level_d, rx_level_q, rx_level_d;

  logic [4:0]           pulse_q, pulse_d;
  logic [NUM_CS-1:0]    csreg_q, csreg_d;
  logic [7:0]           clk_div_q, clk_div_d;
  logic                 clk_div_valid_q, clk_div_valid_d;
  logic [31:0]          cmd_q, cmd_d, addr_q, addr_d;
  logic [5:0]           cmd_len_q, cmd_len_d, addr_len_q, addr_len_d;
  logic [LEN_WIDTH-1:0] data_len_q, data_len_d;
  logic [15:0]          dummy_rd_q, dummy_rd_d, dummy_wr_q, dummy_wr_d;
  logic [LW-1:0]        th_tx_q, th_tx_d, th_rx_q, th_rx_d;
  logic [2:0]           mask_q, mask_d;
  logic                 int_en_q, int_en_d, done_q, done_d, irq_q, irq_d;
  logic [WW-1:0]        wait_q, wait_d;
  logic                 abandon_q, abandon_d;

  assign unused_bits = ^{PADDR, PWDATA};
  assign idx         = PADDR[5:2];

  always_comb begin
    idx_known = 1'b0;
    case (idx)
      IdxStatus, IdxClkDiv, IdxCmd, IdxAddr, IdxLen, IdxDummy,
      IdxTxFifo, IdxRxFifo, IdxIntCfg, IdxIntSta: idx_known = 1'b1;
      default: idx_known = 1'b0;
    endcase
  end

  // An access still on the bus when reset releases is ignored until PSEL drops.
  assign access  = PSEL & PENABLE & ~abandon_q;
  assign map_err = ~idx_known | ((idx == IdxTxFifo) & ~PWRITE) | ((idx == IdxRxFifo) & PWRITE);

  assign tx_full  = (tx_level_q == Depth);
  assign tx_empty = (tx_level_q == '0);
  assign rx_full  = (rx_level_q == Depth);
  assign rx_empty = (rx_level_q == '0);
  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_empty ? '0 : tx_mem_q[tx_rptr_q];
  assign rx_ready = ~rx_full;
  assign tx_pop   = tx_valid & tx_ready;
  assign rx_push  = rx_valid & rx_ready;

  // A full TX FIFO still accepts a push in the cycle the core pops.
  assign stall    = access & ((PWRITE & (idx == IdxTxFifo) & tx_full & ~tx_pop) |
                              (~PWRITE & (idx == IdxRxFifo) & rx_empty));
  assign timeout  = stall & (wait_q == WaitMax);
  assign PREADY   = ~stall | timeout;
  assign done_acc = access & PREADY;
  assign PSLVERR  = done_acc & (map_err | timeout);
  assign wr_ok    = done_acc & PWRITE & ~map_err & ~timeout;
  assign rd_ok    = done_acc & ~PWRITE & ~map_err & ~timeout;
  assign tx_push  = wr_ok & (idx == IdxTxFifo);
  assign rx_pop   = rd_ok & (idx == IdxRxFifo);

  assign intsta = {done_q, (th_rx_q != '0) & (rx_level_q >= th_rx_q), tx_level_q <= th_tx_q};

  always_comb begin
    tx_wptr_d  = tx_wptr_q;
    tx_rptr_d  = tx_rptr_q;
    tx_level_d = tx_level_q;
    rx_wptr_d  = rx_wptr_q;
    rx_rptr_d  = rx_rptr_q;
    rx_level_d = rx_level_q;
    if (pulse_q[4]) begin
      tx_wptr_d  = '0;
      tx_rptr_d  = '0;
      tx_level_d = '0;
      rx_wptr_d  = '0;
      rx_rptr_d  = '0;
      rx_level_d = '0;
    end else begin
      if (tx_push) tx_wptr_d = tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_d = tx_rptr_q + 1'b1;
      if (tx_push && !tx_pop)      tx_level_d = tx_level_q + 1'b1;
      else if (tx_pop && !tx_push) tx_level_d = tx_level_q - 1'b1;
      if (rx_push) rx_wptr_d = rx_wptr_q + 1'b1;
      if (rx_pop)  rx_rptr_d = rx_rptr_q + 1'b1;
      if (rx_push && !rx_pop)      rx_level_d = rx_level_q + 1'b1;
      else if (rx_pop && !rx_push) rx_level_d = rx_level_q - 1'b1;
    end
  end

  always_comb begin
    pulse_d         = '0;
    clk_div_valid_d = 1'b0;
    csreg_d         = csreg_q;
    clk_div_d       = clk_div_q;
    cmd_d           = cmd_q;
    addr_d          = addr_q;
    cmd_len_d       = cmd_len_q;
    addr_len_d      = addr_len_q;
    data_len_d      = data_len_q;
    dummy_rd_d      = dummy_rd_q;
    dummy_wr_d      = dummy_wr_q;
    th_tx_d         = th_tx_q;
    th_rx_d         = th_rx_q;
    mask_d          = mask_q;
    int_en_d        = int_en_q;
    if (wr_ok) begin
      case (idx)
        IdxStatus: begin
          pulse_d = PWDATA[4:0];
          csreg_d = PWDATA[8 +: NUM_CS];
        end
        IdxClkDiv: begin
          clk_div_d       = PWDATA[7:0];
          clk_div_valid_d = 1'b1;
        end
        IdxCmd:  cmd_d  = PWDATA;
        IdxAddr: addr_d = PWDATA;
        IdxLen: begin
          cmd_len_d  = PWDATA[5:0];
          addr_len_d = PWDATA[13:8];
          data_len_d = PWDATA[16 +: LEN_WIDTH];
        end
        IdxDummy: begin
          dummy_rd_d = PWDATA[15:0];
          dummy_wr_d = PWDATA[31:16];
        end
        IdxIntCfg: begin
          th_tx_d  = PWDATA[LW-1:0];
          th_rx_d  = PWDATA[8 +: LW];
          mask_d   = PWDATA[26:24];
          int_en_d = PWDATA[31];
        end
        default: ;
      endcase
    end
    // Set beats clear when core_done coincides with a write-1-to-clear.
    if (pulse_q[4]) done_d = 1'b0;
    else done_d = core_done | (done_q & ~(wr_ok & (idx == IdxIntSta) & PWDATA[2]));
    irq_d = int_en_q & |(intsta & mask_q);
    if (!PSEL || done_acc || pulse_q[4]) wait_d = '0;
    else if (stall)                      wait_d = wait_q + 1'b1;
    else                                 wait_d = wait_q;
    abandon_d = abandon_q & PSEL;
  end

  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      case (idx)
        IdxStatus: begin
          PRDATA[4:0]       = {rx_empty, rx_full, tx_empty, tx_full, core_busy};
          PRDATA[8 +: LW]   = tx_level_q;
          PRDATA[16 +: LW]  = rx_level_q;
        end
        IdxClkDiv: PRDATA[7:0] = clk_div_q;
        IdxCmd:    PRDATA = cmd_q;
        IdxAddr:   PRDATA = addr_q;
        IdxLen: begin
          PRDATA[5:0]             = cmd_len_q;
          PRDATA[13:8]            = addr_len_q;
          PRDATA[16 +: LEN_WIDTH] = data_len_q;
        end
        IdxDummy:  PRDATA = {dummy_wr_q, dummy_rd_q};
        IdxRxFifo: PRDATA = rx_empty ? '0 : rx_mem_q[rx_rptr_q];
        IdxIntCfg: begin
          PRDATA[LW-1:0]  = th_tx_q;
          PRDATA[8 +: LW] = th_rx_q;
          PRDATA[26:24]   = mask_q;
          PRDATA[31]      = int_en_q;
        end
        IdxIntSta: PRDATA[2:0] = intsta;
        default:   PRDATA = '0;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (tx_push) tx_mem_q[tx_wptr_q] <= PWDATA;
    if (rx_push) rx_mem_q[rx_wptr_q] <= rx_data;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      tx_wptr_q       <= '0;
      tx_rptr_q       <= '0;
      tx_level_q      <= '0;
      rx_wptr_q       <= '0;
      rx_rptr_q       <= '0;
      rx_level_q      <= '0;
      pulse_q         <= '0;
      csreg_q         <= '0;
      clk_div_q       <= '0;
      clk_div_valid_q <= 1'b0;
      cmd_q           <= '0;
      addr_q          <= '0;
      cmd_len_q       <= '0;
      addr_len_q      <= '0;
      data_len_q      <= '0;
      dummy_rd_q      <= '0;
      dummy_wr_q      <= '0;
      th_tx_q         <= '0;
      th_rx_q         <= '0;
      mask_q          <= '0;
      int_en_q        <= 1'b0;
      done_q          <= 1'b0;
      irq_q           <= 1'b0;
      wait_q          <= '0;
      abandon_q       <= 1'b1;
    end else begin
      tx_wptr_q       <= tx_wptr_d;
      tx_rptr_q       <= tx_rptr_d;
      tx_level_q      <= tx_level_d;
      rx_wptr_q       <= rx_wptr_d;
      rx_rptr_q       <= rx_rptr_d;
      rx_level_q      <= rx_level_d;
      pulse_q         <= pulse_d;
      csreg_q         <= csreg_d;
      clk_div_q       <= clk_div_d;
      clk_div_valid_q <= clk_div_valid_d;
      cmd_q           <= cmd_d;
      addr_q          <= addr_d;
      cmd_len_q       <= cmd_len_d;
      addr_len_q      <= addr_len_d;
      data_len_q      <= data_len_d;
      dummy_rd_q      <= dummy_rd_d;
      dummy_wr_q      <= dummy_wr_d;
      th_tx_q         <= th_tx_d;
      th_rx_q         <= th_rx_d;
      mask_q          <= mask_d;
      int_en_q        <= int_en_d;
      done_q          <= done_d;
      irq_q           <= irq_d;
      wait_q          <= wait_d;
      abandon_q       <= abandon_d;
    end
  end

  assign {spi_swrst, spi_qwr, spi_qrd, spi_wr, spi_rd} = pulse_q;
  assign spi_csreg         = csreg_q;
  assign spi_clk_div       = clk_div_q;
  assign spi_clk_div_valid = clk_div_valid_q;
  assign spi_cmd           = cmd_q;
  assign spi_addr          = addr_q;
  assign spi_cmd_len       = cmd_len_q;
  assign spi_addr_len      = addr_len_q;
  assign spi_data_len      = data_len_q;
  assign spi_dummy_rd      = dummy_rd_q;
  assign spi_dummy_wr      = dummy_wr_q;
  assign irq               = irq_q;

endmodule
